// File: rtl/hamming_decoder.sv
// -----------------------------------------------------------------------------
// hamming_decoder
//
// Single-error-correcting Hamming(21,16) decoder with registered outputs.
// Parity bits sit at codeword positions 1, 2, 4, 8 and 16, with even parity.
// Data bits data[1..16] fill the remaining positions in ascending order.
// The decode path is purely combinational into the output registers, so
// latency is one cycle and throughput is one codeword per cycle.
//
// Ports
//   clk            in   1       rising-edge clock
//   rst_n          in   1       synchronous active-low reset
//   in_valid       in   1       code_in is valid this cycle
//   code_in        in   [21:1]  received codeword, bit p = position p
//   out_valid      out  1       outputs carry a new result this cycle
//   data_out       out  [16:1]  corrected data word
//   syndrome       out  [5:1]   computed syndrome (binary error position)
//   err_pos        out  [21:1]  one-hot of the corrected position, else 0
//   err_flag       out  1       syndrome nonzero
//   uncorrectable  out  1       syndrome in 22..31 (no valid position)
// -----------------------------------------------------------------------------
module hamming_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [21:1] code_in,
  output logic        out_valid,
  output logic [16:1] data_out,
  output logic [5:1]  syndrome,
  output logic [21:1] err_pos,
  output logic        err_flag,
  output logic        uncorrectable
);

  logic [5:1]  w_syn;
  logic [21:1] w_err_pos;
  logic [21:1] w_corrected;
  logic [16:1] w_data;
  logic        w_err_flag;
  logic        w_uncorrectable;

  logic        r_out_valid;
  logic [16:1] r_data;
  logic [5:1]  r_syn;
  logic [21:1] r_err_pos;
  logic        r_err_flag;
  logic        r_uncorrectable;

  // Syndrome bit k+1 is the parity over every position whose index has bit k
  // set. With an even-parity encoder a clean word yields zero, and a single
  // flipped bit yields its own position number.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_syn = '0;
    for (int p = 1; p <= 21; p++) begin
      for (int k = 0; k < 5; k++) begin
        if (p[k]) begin
          w_syn[k+1] = w_syn[k+1] ^ code_in[p];
        end
      end
    end
  end

  // Only syndromes 1..21 name a real position; 22..31 can only come from a
  // multi-bit error and are reported rather than "corrected".
  always_comb begin
    w_err_pos       = '0;
    w_err_flag      = (w_syn != 5'd0);
    w_uncorrectable = (w_syn > 5'd21);
    if (w_err_flag && !w_uncorrectable) begin
      w_err_pos[w_syn] = 1'b1;
    end
  end

  assign w_corrected = code_in ^ w_err_pos;

  // A corrected parity position leaves the data bits untouched, so the
  // extraction needs no special case for it.
  assign w_data = {w_corrected[21], w_corrected[20], w_corrected[19],
                   w_corrected[18], w_corrected[17], w_corrected[15],
                   w_corrected[14], w_corrected[13], w_corrected[12],
                   w_corrected[11], w_corrected[10], w_corrected[9],
                   w_corrected[7],  w_corrected[6],  w_corrected[5],
                   w_corrected[3]};

  // Result registers load only on a valid input and otherwise hold, so the
  // last decoded word stays visible while out_valid is low.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, because all outputs must
      // read zero after reset, not just out_valid.
      r_out_valid     <= 1'b0;
      r_data          <= '0;
      r_syn           <= '0;
      r_err_pos       <= '0;
      r_err_flag      <= 1'b0;
      r_uncorrectable <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_data          <= w_data;
        r_syn           <= w_syn;
        r_err_pos       <= w_err_pos;
        r_err_flag      <= w_err_flag;
        r_uncorrectable <= w_uncorrectable;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign data_out      = r_data;
  assign syndrome      = r_syn;
  assign err_pos       = r_err_pos;
  assign err_flag      = r_err_flag;
  assign uncorrectable = r_uncorrectable;

endmodule

// File: tb/tb_hamming_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_decoder
//
// Directed, table-driven bench for hamming_decoder. Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_hamming_decoder;

  localparam logic [21:1] CLEAN = 21'h19A3DC;
  localparam logic [16:1] DATA  = 16'hCA3B;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [21:1] code_in;
  logic        out_valid;
  logic [16:1] data_out;
  logic [5:1]  syndrome;
  logic [21:1] err_pos;
  logic        err_flag;
  logic        uncorrectable;

  int n_checks = 0;
  int n_errors = 0;

  hamming_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .code_in       (code_in),
    .out_valid     (out_valid),
    .data_out      (data_out),
    .syndrome      (syndrome),
    .err_pos       (err_pos),
    .err_flag      (err_flag),
    .uncorrectable (uncorrectable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [21:1] code;
    logic [16:1] exp_data;
    logic [5:1]  exp_syn;
    logic [21:1] exp_pos;
    logic        exp_flag;
    logic        exp_unc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string name, input logic exp_valid,
                           input logic [16:1] exp_data, input logic [5:1] exp_syn,
                           input logic [21:1] exp_pos, input logic exp_flag,
                           input logic exp_unc);
    check({name, ".out_valid"},     32'(out_valid),     32'(exp_valid));
    check({name, ".data_out"},      32'(data_out),      32'(exp_data));
    check({name, ".syndrome"},      32'(syndrome),      32'(exp_syn));
    check({name, ".err_pos"},       32'(err_pos),       32'(exp_pos));
    check({name, ".err_flag"},      32'(err_flag),      32'(exp_flag));
    check({name, ".uncorrectable"}, 32'(uncorrectable), 32'(exp_unc));
  endtask

  // Drive one input cycle and sample the registered result after the edge.
  task automatic step(input logic rst_val, input logic vld, input logic [21:1] code);
    @(negedge clk);
    rst_n    = rst_val;
    in_valid = vld;
    code_in  = code;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected values worked out by hand from the bit layout.
    vecs[0] = '{"clean",      CLEAN,                    DATA,     5'd0,  21'h0, 1'b0, 1'b0};
    vecs[1] = '{"zeros",      21'h000000,               16'h0000, 5'd0,  21'h0, 1'b0, 1'b0};
    // All ones: only bit 0 of the position index has an odd count (11).
    vecs[2] = '{"ones",       21'h1FFFFF,               16'hFFFF, 5'd1,  21'h1, 1'b1, 1'b0};
    // Flip 1 and 2: syndrome 3 miscorrects data[1].
    vecs[3] = '{"dbl_1_2",    CLEAN ^ 21'h000003,       16'hCA3A, 5'd3,  21'h4, 1'b1, 1'b0};
    // Flip 8 and 16: syndrome 24 has no position.
    vecs[4] = '{"dbl_8_16",   CLEAN ^ 21'h008080,       DATA,     5'd24, 21'h0, 1'b1, 1'b1};
    // Flip 3 and 5 (data[1], data[2]): syndrome 6 also flips data[3].
    vecs[5] = '{"dbl_3_5",    CLEAN ^ 21'h000014,       16'hCA3C, 5'd6,  21'h20, 1'b1, 1'b0};
    // Flip 15 and 16: syndrome 31, data[11] stays flipped.
    vecs[6] = '{"dbl_15_16",  CLEAN ^ 21'h00C000,       16'hCE3B, 5'd31, 21'h0, 1'b1, 1'b0 | 1'b1};
    vecs[7] = '{"clean_again", CLEAN,                   DATA,     5'd0,  21'h0, 1'b0, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    code_in  = CLEAN;

    // Reset held two cycles with a valid codeword present: it is dropped.
    step(1'b0, 1'b1, CLEAN);
    step(1'b0, 1'b1, CLEAN);
    check_all("reset", 1'b0, 16'h0, 5'd0, 21'h0, 1'b0, 1'b0);

    // First sampled input after release appears one cycle later.
    step(1'b1, 1'b1, CLEAN);
    check_all("first", 1'b1, DATA, 5'd0, 21'h0, 1'b0, 1'b0);

    // Table vectors, back-to-back.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, vecs[i].code);
      check_all(vecs[i].name, 1'b1, vecs[i].exp_data, vecs[i].exp_syn,
                vecs[i].exp_pos, vecs[i].exp_flag, vecs[i].exp_unc);
    end

    // Single-bit sweep: every position is corrected back to the clean data.
    for (int p = 1; p <= 21; p++) begin
      logic [21:1] one_hot;
      one_hot = 21'h1 << (p - 1);
      step(1'b1, 1'b1, CLEAN ^ one_hot);
      check_all($sformatf("sweep%0d", p), 1'b1, DATA, 5'(p), one_hot, 1'b1, 1'b0);
    end

    // Valid gating: load a known result, then idle with a changing input.
    step(1'b1, 1'b1, vecs[4].code);
    check_all("pre_hold", 1'b1, DATA, 5'd24, 21'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, CLEAN ^ 21'h000001);
    check_all("hold1", 1'b0, DATA, 5'd24, 21'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 21'h1FFFFF);
    check_all("hold2", 1'b0, DATA, 5'd24, 21'h0, 1'b1, 1'b1);

    // Reset directly after a valid input: no result is produced.
    step(1'b1, 1'b1, CLEAN ^ 21'h000004);
    check_all("pre_rst", 1'b1, DATA, 5'd3, 21'h4, 1'b1, 1'b0);
    step(1'b0, 1'b1, CLEAN ^ 21'h000010);
    check_all("rst_after_valid", 1'b0, 16'h0, 5'd0, 21'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, CLEAN);
    check_all("idle_after_rst", 1'b0, 16'h0, 5'd0, 21'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
